// File: rtl/reg_file_32x32_pkg.sv
// Shared register-file definitions: widths, entry count and the constants
// used for the hardwired zero register. Also consumed by the ALU/datapath.
package reg_file_32x32_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_COUNT  = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX  = 5'b00000;
  localparam logic [DATA_WIDTH-1:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/reg_file_32x32_reg32_ld.sv
// reg32_ld: word register with load enable and asynchronous active-high clear.
// The load path is an explicit hold/load 2x1 mux in front of the flops.
module reg32_ld #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_d;

  assign w_d = i_ld ? i_d : r_q;

  // Word storage: clear on reset, otherwise take the hold/load mux output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else begin
      r_q <= w_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_file_32x32.sv
// reg_file_32x32: 32 x 32-bit register file, two registered read ports and
// one write port, register 0 hardwired to zero.
// Build option: define REGFILE_BYPASS_EN to make simultaneous READ/WRITE legal
// with write-through forwarding to read ports that address the written index.
// Without it, READ and WRITE on the same edge is a no-op.
module reg_file_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  input  logic                  READ,
  input  logic                  WRITE,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  R_VALID
);

  import reg_file_32x32_pkg::*;

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] W_ZERO_IDX  = ADDR_WIDTH'(ZERO_IDX);
  localparam logic [DATA_WIDTH-1:0] W_ZERO_WORD = DATA_WIDTH'(ZERO_WORD);

  logic                  w_wr_go;
  logic                  w_rd_go;
  logic [NREG-1:1]       w_we;
  logic [DATA_WIDTH-1:0] w_bank [NREG];
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;
  logic                  r_valid;

`ifdef REGFILE_BYPASS_EN
  assign w_wr_go = WRITE;
  assign w_rd_go = READ;
`else
  assign w_wr_go = WRITE & ~READ;
  assign w_rd_go = READ & ~WRITE;
`endif

  // 5-to-32 write-enable decoder; index 0 has no storage so it gets no enable.
  always_comb begin
    w_we = '0;
    for (int i = 1; i < NREG; i++) begin
      if (w_wr_go && (ADDR_W == ADDR_WIDTH'(i))) begin
        w_we[i] = 1'b1;
      end
    end
  end

  assign w_bank[0] = W_ZERO_WORD;

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_reg
      reg32_ld #(.WIDTH(DATA_WIDTH)) u_reg (
        .i_clk (CLK),
        .i_rst (RST),
        .i_ld  (w_we[g]),
        .i_d   (DATA_W),
        .o_q   (w_bank[g])
      );
    end
  endgenerate

  // Per-port 32x1 word select, with optional forwarding of the in-flight write.
  always_comb begin
    w_rd1 = w_bank[ADDR_R1];
    w_rd2 = w_bank[ADDR_R2];
`ifdef REGFILE_BYPASS_EN
    if (WRITE && (ADDR_W != W_ZERO_IDX)) begin
      if (ADDR_R1 == ADDR_W) w_rd1 = DATA_W;
      if (ADDR_R2 == ADDR_W) w_rd2 = DATA_W;
    end
`endif
  end

  reg32_ld #(.WIDTH(DATA_WIDTH)) u_dr1 (
    .i_clk (CLK),
    .i_rst (RST),
    .i_ld  (w_rd_go),
    .i_d   (w_rd1),
    .o_q   (DATA_R1)
  );

  reg32_ld #(.WIDTH(DATA_WIDTH)) u_dr2 (
    .i_clk (CLK),
    .i_rst (RST),
    .i_ld  (w_rd_go),
    .i_d   (w_rd2),
    .o_q   (DATA_R2)
  );

  // Read-valid pulse: high for the cycle after every accepted read edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd_go;
    end
  end

  assign R_VALID = r_valid;

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed bench for reg_file_32x32: table of single-edge vectors with
// hand-computed expectations plus reset sequences.
module tb_reg_file_32x32;

  logic        CLK;
  logic        RST;
  logic [4:0]  ADDR_R1;
  logic [4:0]  ADDR_R2;
  logic [4:0]  ADDR_W;
  logic [31:0] DATA_W;
  logic        READ;
  logic        WRITE;
  logic [31:0] DATA_R1;
  logic [31:0] DATA_R2;
  logic        R_VALID;

  logic clk_en;
  int   n_checks;
  int   n_errors;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  aw;
    logic [31:0] dw;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ev;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  reg_file_32x32 dut (
    .CLK     (CLK),
    .RST     (RST),
    .ADDR_R1 (ADDR_R1),
    .ADDR_R2 (ADDR_R2),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .READ    (READ),
    .WRITE   (WRITE),
    .DATA_R1 (DATA_R1),
    .DATA_R2 (DATA_R2),
    .R_VALID (R_VALID)
  );

  initial begin
    CLK = 1'b0;
    forever begin
      #5;
      if (clk_en) CLK = ~CLK;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int k, input logic rd, input logic wr,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] aw, input logic [31:0] dw,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic ev);
    tbl[k].rd = rd; tbl[k].wr = wr;
    tbl[k].a1 = a1; tbl[k].a2 = a2; tbl[k].aw = aw; tbl[k].dw = dw;
    tbl[k].e1 = e1; tbl[k].e2 = e2; tbl[k].ev = ev;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] aw, input logic [31:0] dw);
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDR_R1 = a1; ADDR_R2 = a2; ADDR_W = aw; DATA_W = dw;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk_en   = 1'b0;
    RST      = 1'b0;
    READ = 1'b0; WRITE = 1'b0;
    ADDR_R1 = '0; ADDR_R2 = '0; ADDR_W = '0; DATA_W = '0;

    // columns: rd wr a1 a2 aw dw | DATA_R1 DATA_R2 R_VALID
    set_vec(0,  0, 1, 5'd0,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        32'h0,        0);
    set_vec(1,  0, 1, 5'd0,  5'd0,  5'd31, 32'h12345678, 32'h0,        32'h0,        0);
    set_vec(2,  1, 0, 5'd5,  5'd31, 5'd0,  32'h0,        32'hDEADBEEF, 32'h12345678, 1);
    set_vec(3,  0, 0, 5'd5,  5'd31, 5'd0,  32'h0,        32'hDEADBEEF, 32'h12345678, 0);
    set_vec(4,  0, 0, 5'd31, 5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'h12345678, 0);
    set_vec(5,  0, 0, 5'd2,  5'd3,  5'd0,  32'h0,        32'hDEADBEEF, 32'h12345678, 0);
    set_vec(6,  0, 1, 5'd2,  5'd3,  5'd0,  32'hFFFFFFFF, 32'hDEADBEEF, 32'h12345678, 0);
    set_vec(7,  1, 0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        1);
    set_vec(8,  1, 0, 5'd5,  5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1);
    set_vec(9,  0, 1, 5'd5,  5'd5,  5'd7,  32'h00000001, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    set_vec(10, 1, 0, 5'd7,  5'd31, 5'd0,  32'h0,        32'h00000001, 32'h12345678, 1);
    set_vec(11, 0, 1, 5'd7,  5'd31, 5'd9,  32'hCAFEF00D, 32'h00000001, 32'h12345678, 0);
    set_vec(12, 1, 0, 5'd9,  5'd7,  5'd0,  32'h0,        32'hCAFEF00D, 32'h00000001, 1);
`ifdef REGFILE_BYPASS_EN
    set_vec(13, 1, 1, 5'd7,  5'd9,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hCAFEF00D, 1);
    set_vec(14, 1, 0, 5'd7,  5'd7,  5'd0,  32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 1);
    set_vec(15, 1, 1, 5'd0,  5'd9,  5'd0,  32'hFFFFFFFF, 32'h0,        32'hCAFEF00D, 1);
`else
    set_vec(13, 1, 1, 5'd7,  5'd9,  5'd7,  32'hA5A5A5A5, 32'hCAFEF00D, 32'h00000001, 0);
    set_vec(14, 1, 0, 5'd7,  5'd7,  5'd0,  32'h0,        32'h00000001, 32'h00000001, 1);
    set_vec(15, 1, 1, 5'd0,  5'd9,  5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0);
`endif
    set_vec(16, 1, 0, 5'd0,  5'd9,  5'd0,  32'h0,        32'h0,        32'hCAFEF00D, 1);

    // Asynchronous reset with the clock stopped
    #3 RST = 1'b1;
    #1;
    check("rst_dr1", DATA_R1, 32'h0);
    check("rst_dr2", DATA_R2, 32'h0);
    check("rst_vld", {31'h0, R_VALID}, 32'h0);
    #5 RST = 1'b0;
    clk_en = 1'b1;

    // Every index reads zero after reset
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0);
      check($sformatf("rst_scan_r1_%0d", i), DATA_R1, 32'h0);
      check($sformatf("rst_scan_r2_%0d", i), DATA_R2, 32'h0);
      check($sformatf("rst_scan_v_%0d", i), {31'h0, R_VALID}, 32'h1);
    end

    // Table vectors
    for (int k = 0; k < NVEC; k++) begin
      drive(tbl[k].rd, tbl[k].wr, tbl[k].a1, tbl[k].a2, tbl[k].aw, tbl[k].dw);
      check($sformatf("vec%0d_dr1", k), DATA_R1, tbl[k].e1);
      check($sformatf("vec%0d_dr2", k), DATA_R2, tbl[k].e2);
      check($sformatf("vec%0d_vld", k), {31'h0, R_VALID}, {31'h0, tbl[k].ev});
    end

    // Reset asserted around a write edge: the write must be dropped
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b1; ADDR_W = 5'd3; DATA_W = 32'h00000055; RST = 1'b1;
    #1;
    check("midrst_dr1", DATA_R1, 32'h0);
    check("midrst_dr2", DATA_R2, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0; WRITE = 1'b0;
    drive(1'b1, 1'b0, 5'd3, 5'd5, 5'd0, 32'h0);
    check("midrst_r3", DATA_R1, 32'h0);
    check("midrst_r5", DATA_R2, 32'h0);
    check("midrst_vld", {31'h0, R_VALID}, 32'h1);
    drive(1'b0, 1'b0, 5'd3, 5'd5, 5'd0, 32'h0);
    check("midrst_vld_drop", {31'h0, R_VALID}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
